// File: rtl/id_ex_ctrl_decode_pkg.sv
// id_ex_ctrl_decode_pkg: opcodes, ALU/ImmSrc/ResultSrc codes and the E-stage control bundle
package id_ex_ctrl_decode_pkg;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_XOR = 3'b111
  } aluCtrl_e;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} immSrc_e;

  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} resultSrc_e;

  typedef struct packed {
    logic       regWrite;
    resultSrc_e resultSrc;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic       aluSrc;
    aluCtrl_e   aluControl;
    logic       illegal;
  } ctrlE_t;

  // Bubble: every control zero, so an inserted slot has no architectural effect
  localparam ctrlE_t CTRL_BUBBLE = '{
    regWrite: 1'b0, resultSrc: RES_ALU, memWrite: 1'b0, jump: 1'b0,
    branch: 1'b0, aluSrc: 1'b0, aluControl: ALU_ADD, illegal: 1'b0
  };

  // funct3 of R/I-ALU ops to ALU code; subSel picks sub for funct3 000
  function automatic aluCtrl_e funct3ToAlu(input logic [2:0] funct3, input logic subSel);
    case (funct3)
      3'b000:  return subSel ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/id_ex_ctrl_decode_if.sv
// id_ex_ctrl_decode_if: decode-stage inputs and E-stage control outputs
interface id_ex_ctrl_decode_if #(parameter int REG_AW = 5);
  logic [31:0]       InstrD;
  logic              StallE;
  logic              FlushE;
  logic [1:0]        ImmSrcD;
  logic              RegWriteE;
  logic [1:0]        ResultSrcE;
  logic              MemWriteE;
  logic              JumpE;
  logic              BranchE;
  logic              ALUSrcE;
  logic [2:0]        ALUControlE;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic              IllegalE;

  modport master (
    output InstrD, StallE, FlushE,
    input  ImmSrcD, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ALUControlE, Rs1E, Rs2E, RdE, IllegalE
  );

  modport slave (
    input  InstrD, StallE, FlushE,
    output ImmSrcD, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ALUControlE, Rs1E, Rs2E, RdE, IllegalE
  );
endinterface

// File: rtl/id_ex_ctrl_decode_alu_ctrl_dec.sv
// alu_ctrl_dec: ALU control and funct3/funct7[5] legality from opcode class
module alu_ctrl_dec
  import id_ex_ctrl_decode_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output aluCtrl_e   aluControl,
  output logic       illegal
);
  logic isR;
  logic aluOp;

  // Memory and jal use add, beq compares with sub; sltu and sra/srai/slli-with-b5 are unsupported
  always_comb begin
    isR = opcode == OP_R;
    aluOp = isR || opcode == OP_IALU;
    aluControl = opcode == OP_BEQ ? ALU_SUB : aluOp ? funct3ToAlu(funct3, isR && funct7b5) : ALU_ADD;
    illegal = aluOp && (funct3 == 3'b011 || (funct7b5 && funct3 != 3'b000 && (isR || funct3[1:0] == 2'b01)));
  end
endmodule

// File: rtl/id_ex_ctrl_decode.sv
// id_ex_ctrl_decode: D-stage main decode plus ID/EX control pipeline register
module id_ex_ctrl_decode
  import id_ex_ctrl_decode_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter bit ILLEGAL_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  id_ex_ctrl_decode_if.slave bus
);
  logic [6:0]        opcode;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic              f7Rest;
  logic              aluIllegal;
  logic              illegalD;
  aluCtrl_e          aluControlD;
  immSrc_e           immSel;
  ctrlE_t            mainD;
  ctrlE_t            ctrlD;
  ctrlE_t            ctrlE;
  logic [REG_AW-1:0] rs1E;
  logic [REG_AW-1:0] rs2E;
  logic [REG_AW-1:0] rdE;

  assign opcode = bus.InstrD[6:0];
  assign funct3 = bus.InstrD[14:12];
  assign funct7 = bus.InstrD[31:25];
  assign f7Rest = |{funct7[6], funct7[4:0]};

  alu_ctrl_dec uAluDec (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7b5  (funct7[5]),
    .aluControl(aluControlD),
    .illegal   (aluIllegal)
  );

  // Main decode per opcode; illegal encodings collapse to a bubble, rd=0 suppresses the write
  always_comb begin
    mainD = CTRL_BUBBLE;
    mainD.aluControl = aluControlD;
    immSel = IMM_I;
    illegalD = 1'b0;
    case (opcode)
      OP_LW: begin
        mainD.regWrite = 1'b1;
        mainD.resultSrc = RES_MEM;
        mainD.aluSrc = 1'b1;
        illegalD = funct3 != 3'b010;
      end
      OP_SW: begin
        mainD.memWrite = 1'b1;
        mainD.aluSrc = 1'b1;
        immSel = IMM_S;
        illegalD = funct3 != 3'b010;
      end
      OP_R: begin
        mainD.regWrite = 1'b1;
        illegalD = aluIllegal || f7Rest;
      end
      OP_IALU: begin
        mainD.regWrite = 1'b1;
        mainD.aluSrc = 1'b1;
        illegalD = aluIllegal || (funct3[1:0] == 2'b01 && f7Rest);
      end
      OP_BEQ: begin
        mainD.branch = 1'b1;
        immSel = IMM_B;
        illegalD = funct3 != 3'b000;
      end
      OP_JAL: begin
        mainD.jump = 1'b1;
        mainD.regWrite = 1'b1;
        mainD.resultSrc = RES_PC4;
        immSel = IMM_J;
      end
      default: illegalD = 1'b1;
    endcase
    ctrlD = illegalD ? CTRL_BUBBLE : mainD;
    ctrlD.illegal = illegalD && ILLEGAL_EN;
    ctrlD.regWrite = ctrlD.regWrite && bus.InstrD[11:7] != 5'd0;
  end

  // E-stage register: reset and flush load a bubble, stall holds, otherwise capture D
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) begin
      ctrlE <= CTRL_BUBBLE;
      rs1E <= '0;
      rs2E <= '0;
      rdE <= '0;
    end else if (!bus.StallE) begin
      ctrlE <= ctrlD;
      rs1E <= illegalD ? '0 : REG_AW'(bus.InstrD[19:15]);
      rs2E <= illegalD ? '0 : REG_AW'(bus.InstrD[24:20]);
      rdE <= illegalD ? '0 : REG_AW'(bus.InstrD[11:7]);
    end
  end

  assign bus.ImmSrcD     = illegalD ? IMM_I : immSel;
  assign bus.RegWriteE   = ctrlE.regWrite;
  assign bus.ResultSrcE  = ctrlE.resultSrc;
  assign bus.MemWriteE   = ctrlE.memWrite;
  assign bus.JumpE       = ctrlE.jump;
  assign bus.BranchE     = ctrlE.branch;
  assign bus.ALUSrcE     = ctrlE.aluSrc;
  assign bus.ALUControlE = ctrlE.aluControl;
  assign bus.IllegalE    = ctrlE.illegal;
  assign bus.Rs1E        = rs1E;
  assign bus.Rs2E        = rs2E;
  assign bus.RdE         = rdE;
endmodule

// File: tb/tb_id_ex_ctrl_decode.sv
// tb_id_ex_ctrl_decode: directed checks of decode, pipeline register, stall/flush and illegal handling
module tb_id_ex_ctrl_decode;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] vec;
  logic [31:0] vec0;

  id_ex_ctrl_decode_if #(.REG_AW(5)) bus ();
  id_ex_ctrl_decode_if #(.REG_AW(5)) bus0 ();

  id_ex_ctrl_decode #(.REG_AW(5), .ILLEGAL_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  id_ex_ctrl_decode #(.REG_AW(5), .ILLEGAL_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  assign bus0.InstrD = bus.InstrD;
  assign bus0.StallE = bus.StallE;
  assign bus0.FlushE = bus.FlushE;

  assign vec = {6'd0, bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE, bus.BranchE, bus.ALUSrcE,
                bus.ALUControlE, bus.IllegalE, bus.Rs1E, bus.Rs2E, bus.RdE};
  assign vec0 = {6'd0, bus0.RegWriteE, bus0.ResultSrcE, bus0.MemWriteE, bus0.JumpE, bus0.BranchE, bus0.ALUSrcE,
                 bus0.ALUControlE, bus0.IllegalE, bus0.Rs1E, bus0.Rs2E, bus0.RdE};

  always #5 clk = ~clk;

  function automatic logic [31:0] ev(input logic rw, input logic [1:0] rs, input logic mw, input logic j,
                                     input logic b, input logic as, input logic [2:0] alu, input logic ill,
                                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    return {6'd0, rw, rs, mw, j, b, as, alu, ill, r1, r2, rd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic stall, input logic flush);
    bus.InstrD = instr;
    bus.StallE = stall;
    bus.FlushE = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  f3s [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0]  alus[7] = '{3'b000, 3'b100, 3'b101, 3'b111, 3'b110, 3'b011, 3'b010};
  logic [31:0] bad [9] = '{32'h0062B2B3, 32'h4062D2B3, 32'h0000007F, 32'h00000000, 32'h02051513,
                           32'h0004_8303, 32'h00629463, 32'h02B50533, 32'h4025D513};
  logic [31:0] instr;

  initial begin
    bus.InstrD = 32'h00000013;
    bus.StallE = 1'b0;
    bus.FlushE = 1'b0;
    tick();
    chk("reset c1", vec, 32'd0);
    tick();
    chk("reset c2", vec, 32'd0);
    chk("reset c2 noill", vec0, 32'd0);
    reset = 1'b0;
    tick();
    chk("nop", vec, ev(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0));

    drive(32'h40B50533, 1'b0, 1'b0);
    chk("sub imm", 32'(bus.ImmSrcD), 32'd0);
    tick();
    chk("sub", vec, ev(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd10, 5'd11, 5'd10));
    chk("sub noill", vec0, ev(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd10, 5'd11, 5'd10));

    drive(32'h0004A303, 1'b0, 1'b0);
    chk("lw imm", 32'(bus.ImmSrcD), 32'd0);
    tick();
    chk("lw", vec, ev(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 5'd9, 5'd0, 5'd6));
    drive(32'h0064A423, 1'b0, 1'b0);
    chk("sw imm", 32'(bus.ImmSrcD), 32'd1);
    tick();
    chk("sw", vec, ev(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 5'd9, 5'd6, 5'd8));
    drive(32'h00628463, 1'b0, 1'b0);
    chk("beq imm", 32'(bus.ImmSrcD), 32'd2);
    tick();
    chk("beq", vec, ev(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 5'd5, 5'd6, 5'd8));
    drive(32'h008000EF, 1'b0, 1'b0);
    chk("jal imm", 32'(bus.ImmSrcD), 32'd3);
    tick();
    chk("jal", vec, ev(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 5'd8, 5'd1));

    drive(32'h00B50533, 1'b0, 1'b0);
    tick();
    chk("add load", vec, ev(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd10, 5'd11, 5'd10));
    drive(32'h00B54533, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall hold %0d", i), vec,
          ev(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd10, 5'd11, 5'd10));
    end
    drive(32'h00B54533, 1'b1, 1'b1);
    tick();
    chk("stall+flush", vec, 32'd0);
    drive(32'h00B54533, 1'b0, 1'b0);
    tick();
    chk("xor after flush", vec, ev(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 5'd10, 5'd11, 5'd10));
    drive(32'h00B50533, 1'b0, 1'b1);
    tick();
    chk("flush", vec, 32'd0);

    for (int i = 0; i < 9; i++) begin
      drive(bad[i], 1'b0, 1'b0);
      chk($sformatf("illegal imm %h", bad[i]), 32'(bus.ImmSrcD), 32'd0);
      tick();
      chk($sformatf("illegal %h", bad[i]), vec,
          ev(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd0, 5'd0, 5'd0));
      chk($sformatf("illegal noill %h", bad[i]), vec0, 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      for (int z = 0; z < 2; z++) begin
        instr = {7'h00, 5'd3, 5'd2, f3s[i], z == 1 ? 5'd0 : 5'd5, 7'h33};
        drive(instr, 1'b0, 1'b0);
        tick();
        chk($sformatf("R f3=%0d rd0=%0d", f3s[i], z), vec,
            ev(z == 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, alus[i], 1'b0, 5'd2, 5'd3, z == 1 ? 5'd0 : 5'd5));
        instr = {f3s[i][1:0] == 2'b01 ? 7'h00 : 7'h23, 5'd7, 5'd2, f3s[i], z == 1 ? 5'd0 : 5'd5, 7'h13};
        drive(instr, 1'b0, 1'b0);
        tick();
        chk($sformatf("I f3=%0d rd0=%0d", f3s[i], z), vec,
            ev(z == 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, alus[i], 1'b0, 5'd2, 5'd7, z == 1 ? 5'd0 : 5'd5));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
